// File: rtl/div_pkg.sv
// Shared op encodings, FSM state type and op-decoding helpers for the iterative divider.
package div_pkg;

  localparam int unsigned DIV_OP_WIDTH = 2;

  localparam logic [DIV_OP_WIDTH-1:0] OP_DIV  = 2'd0;
  localparam logic [DIV_OP_WIDTH-1:0] OP_DIVU = 2'd1;
  localparam logic [DIV_OP_WIDTH-1:0] OP_REM  = 2'd2;
  localparam logic [DIV_OP_WIDTH-1:0] OP_REMU = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input logic [DIV_OP_WIDTH-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [DIV_OP_WIDTH-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem_c,
  output logic [XLEN-1:0] o_quo_c
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // i_quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};

  assign o_rem_c = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quo_c = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/divider_xlen.sv
// Iterative restoring integer divider (DIV/DIVU/REM/REMU) with tag echo, flush and
// valid/ready handshakes on both sides.
module divider_xlen
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned BPC   = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIV_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]         dividend,
  input  logic [XLEN-1:0]         divisor,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         result,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    div_by_zero
);

  localparam int unsigned ITER  = XLEN / BPC;
  localparam int unsigned CNT_W = $clog2(ITER);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_dvsr;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [TAG_W-1:0] r_tag;
  logic             r_dbz;
  logic [XLEN-1:0]  r_result;
  logic             r_in_ready;
  logic             r_out_valid;

  logic            w_accept;
  logic            w_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_last;

  logic [XLEN-1:0] w_rem [BPC+1];
  logic [XLEN-1:0] w_quo [BPC+1];

  assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;
  assign w_sgn    = op_is_signed(op);
  assign w_a_neg  = w_sgn && dividend[XLEN-1];
  assign w_b_neg  = w_sgn && divisor[XLEN-1];
  assign w_a_abs  = w_a_neg ? -dividend : dividend;
  assign w_b_abs  = w_b_neg ? -divisor : divisor;
  assign w_zero   = (divisor == '0);
  assign w_ovf    = w_sgn && (dividend == MIN_NEG) && (&divisor);
  assign w_last   = (r_cnt == CNT_W'(ITER - 1));

  // BPC restoring steps chained combinationally per CALC cycle.
  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .i_rem   (w_rem[g]),
      .i_quo   (w_quo[g]),
      .i_dvsr  (r_dvsr),
      .o_rem_c (w_rem[g+1]),
      .o_quo_c (w_quo[g+1])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (w_zero || w_ovf) ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  // Handshake flags track the next state so they stay registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_tag    <= '0;
      r_dbz    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= w_a_abs;
      r_dvsr   <= w_b_abs;
      r_is_rem <= op_is_rem(op);
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_tag    <= in_tag;
      r_dbz    <= w_zero;
      if (w_zero)     r_result <= op_is_rem(op) ? dividend : '1;
      else if (w_ovf) r_result <= op_is_rem(op) ? '0 : dividend;
    end else if (r_state == ST_CALC) begin
      r_rem <= w_rem[BPC];
      r_quo <= w_quo[BPC];
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == ST_FIX) begin
      if (r_is_rem) r_result <= r_neg_r ? -r_rem : r_rem;
      else          r_result <= r_neg_q ? -r_quo : r_quo;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign out_tag     = r_tag;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_xlen.sv
// Directed bench for divider_xlen: a default 32-bit/1-bit-per-cycle instance and a 64-bit/2-bit one.
module tb_divider_xlen;
  import div_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic flush;

  logic        v32, rdy32, ov32, ordy32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32;
  logic [4:0]  tag32, otag32;

  logic        v64, rdy64, ov64, ordy64, dbz64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;
  logic [4:0]  tag64, otag64;

  int n_total = 0;
  int n_bad   = 0;

  divider_xlen u_dut32 (
    .clk(clk), .resetn(resetn), .in_valid(v32), .in_ready(rdy32), .op(op32),
    .dividend(a32), .divisor(b32), .in_tag(tag32), .flush(flush),
    .out_valid(ov32), .out_ready(ordy32), .result(res32), .out_tag(otag32),
    .div_by_zero(dbz32)
  );

  divider_xlen #(.XLEN(64), .BPC(2), .TAG_W(5)) u_dut64 (
    .clk(clk), .resetn(resetn), .in_valid(v64), .in_ready(rdy64), .op(op64),
    .dividend(a64), .divisor(b64), .in_tag(tag64), .flush(1'b0),
    .out_valid(ov64), .out_ready(ordy64), .result(res64), .out_tag(otag64),
    .div_by_zero(dbz64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run32(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_res,
                       input logic exp_dbz, input int exp_lat);
    int lat;
    chk({name, ".ready"}, 64'(rdy32), 64'd1);
    v32 = 1'b1; op32 = op; a32 = a; b32 = b; tag32 = tag;
    @(posedge clk); #1;
    v32 = 1'b0; a32 = $urandom(); b32 = $urandom(); tag32 = 5'($urandom());
    lat = 1;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({name, ".res"}, 64'(res32), 64'(exp_res));
    chk({name, ".dbz"}, 64'(dbz32), 64'(exp_dbz));
    chk({name, ".tag"}, 64'(otag32), 64'(tag));
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;
    chk({name, ".idle_rdy"}, 64'(rdy32), 64'd1);
    chk({name, ".idle_ov"}, 64'(ov32), 64'd0);
  endtask

  task automatic run64(input string name, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp_res,
                       input logic exp_dbz, input int exp_lat);
    int lat;
    v64 = 1'b1; op64 = op; a64 = a; b64 = b; tag64 = tag;
    @(posedge clk); #1;
    v64 = 1'b0; a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
    lat = 1;
    while (!ov64 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({name, ".res"}, res64, exp_res);
    chk({name, ".dbz"}, 64'(dbz64), 64'(exp_dbz));
    chk({name, ".tag"}, 64'(otag64), 64'(tag));
    ordy64 = 1'b1;
    @(posedge clk); #1;
    ordy64 = 1'b0;
    chk({name, ".idle_rdy"}, 64'(rdy64), 64'd1);
  endtask

  task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
    v32 = 1'b1; op32 = op; a32 = a; b32 = b; tag32 = tag;
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  initial begin
    int seen;
    resetn = 1'b0; flush = 1'b0;
    v32 = 1'b0; ordy32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; tag32 = '0;
    v64 = 1'b0; ordy64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; tag64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ov", 64'(ov32), 64'd0);
    chk("rst.rdy", 64'(rdy32), 64'd1);
    chk("rst.res", 64'(res32), 64'd0);
    chk("rst.tag", 64'(otag32), 64'd0);
    chk("rst.dbz", 64'(dbz32), 64'd0);
    resetn = 1'b1;

    run32("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,          5'd1,  32'hFFFF_FFFD, 1'b0, 34);
    run32("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2,          5'd2,  32'hFFFF_FFFF, 1'b0, 34);
    run32("divu_z",     OP_DIVU, 32'hFFFF_FFFF, 32'd0,          5'd3,  32'hFFFF_FFFF, 1'b1, 1);
    run32("remu_z",     OP_REMU, 32'hFFFF_FFFF, 32'd0,          5'd4,  32'hFFFF_FFFF, 1'b1, 1);
    run32("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  5'd5,  32'h8000_0000, 1'b0, 1);
    run32("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  5'd6,  32'h0000_0000, 1'b0, 1);
    run32("divu_100_7", OP_DIVU, 32'd100,       32'd7,          5'd7,  32'd14,        1'b0, 34);
    run32("remu_100_7", OP_REMU, 32'd100,       32'd7,          5'd8,  32'd2,         1'b0, 34);
    run32("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD, 1'b0, 34);
    run32("rem_7_m2",   OP_REM,  32'd7,         32'hFFFF_FFFE,  5'd10, 32'd1,         1'b0, 34);
    run32("div_m8_m3",  OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD,  5'd11, 32'd2,         1'b0, 34);
    run32("rem_m8_m3",  OP_REM,  32'hFFFF_FFF8, 32'hFFFF_FFFD,  5'd12, 32'hFFFF_FFFE, 1'b0, 34);
    run32("div_min_2",  OP_DIV,  32'h8000_0000, 32'd2,          5'd13, 32'hC000_0000, 1'b0, 34);
    run32("rem_m5_z",   OP_REM,  32'hFFFF_FFFB, 32'd0,          5'd14, 32'hFFFF_FFFB, 1'b1, 1);
    run32("divu_min",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  5'd15, 32'd0,         1'b0, 34);
    run32("remu_min",   OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF,  5'd16, 32'h8000_0000, 1'b0, 34);

    run64("u64_div", OP_DIVU, 64'd1000, 64'd7, 5'h15, 64'd142, 1'b0, 34);
    run64("u64_rem", OP_REMU, 64'd1000, 64'd7, 5'h0A, 64'd6,   1'b0, 34);
    run64("s64_div", OP_DIV,  64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'h1F, 64'hFFFF_FFFF_FFFF_FF72, 1'b0, 34);
    run64("s64_rem", OP_REM,  64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'h11, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 34);
    run64("u64_z",   OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'h02, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);

    // Hold result in DONE while the consumer stalls.
    start32(OP_DIVU, 32'd100, 32'd7, 5'd9);
    seen = 1;
    while (!ov32 && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("hold.lat", 64'(seen), 64'd34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold.res", 64'(res32), 64'd14);
      chk("hold.tag", 64'(otag32), 64'd9);
      chk("hold.rdy", 64'(rdy32), 64'd0);
      chk("hold.ov", 64'(ov32), 64'd1);
    end
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;
    chk("hold.rel_rdy", 64'(rdy32), 64'd1);
    chk("hold.rel_ov", 64'(ov32), 64'd0);

    // Flush mid-CALC.
    start32(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd20);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.rdy", 64'(rdy32), 64'd1);
    chk("flush.ov", 64'(ov32), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    chk("flush.no_ov", 64'(seen), 64'd0);

    // Flush together with a request in IDLE discards it.
    v32 = 1'b1; op32 = OP_DIVU; a32 = 32'd5; b32 = 32'd0; tag32 = 5'd21; flush = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; flush = 1'b0;
    chk("flush_acc.rdy", 64'(rdy32), 64'd1);
    chk("flush_acc.ov", 64'(ov32), 64'd0);
    run32("post_flush", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd22, 32'hFFFF_FFFD, 1'b0, 34);

    // Asynchronous reset mid-CALC.
    start32(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd23);
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst.rdy", 64'(rdy32), 64'd1);
    chk("arst.ov", 64'(ov32), 64'd0);
    chk("arst.res", 64'(res32), 64'd0);
    chk("arst.tag", 64'(otag32), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run32("post_rst", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd24, 32'hFFFF_FFFF, 1'b0, 34);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_xlen.md
DIVIDER_XLEN -- requirements
Module: divider_xlen

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; legal values 32 and 64.
REQ-002 Parameter BPC, default 1, quotient bits resolved per CALC cycle; legal values 1 and 2.
REQ-003 Parameter TAG_W, default 5, width of the opaque tag echoed with each result.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 op  input  DIV_OP_WIDTH  DIV, DIVU, REM or REMU.
REQ-009 dividend  input  XLEN  dividend operand.
REQ-010 divisor  input  XLEN  divisor operand.
REQ-011 in_tag  input  TAG_W  request tag.
REQ-012 flush  input  1  abort the in-flight operation.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 result  output  XLEN  quotient or remainder, selected by the latched op.
REQ-016 out_tag  output  TAG_W  tag of the request that produced result.
REQ-017 div_by_zero  output  1  divisor was zero; qualified by out_valid.

Function
REQ-018 States: IDLE, CALC, FIX, DONE; in_ready shall equal (state==IDLE).
REQ-019 Accept on the rising edge with in_valid && in_ready; op, operands (absolute values when signed) and tag are latched, and inputs are don't-care afterwards.
REQ-020 Divisor==0 at accept: IDLE->DONE; quotient all-ones; remainder = dividend; div_by_zero=1.
REQ-021 Signed op with dividend = most-negative value and divisor = -1 at accept: IDLE->DONE; quotient = dividend; remainder = 0; div_by_zero=0.
REQ-022 All other requests: IDLE->CALC; CALC runs exactly XLEN/BPC cycles, applying BPC restoring steps per cycle; then CALC->FIX.
REQ-023 Each restoring step subtracts the divisor magnitude from the shifted partial remainder at XLEN+1 bits; a non-negative difference sets the quotient bit and replaces the remainder.
REQ-024 In FIX, when signed and the operand signs differ, the quotient is negated.
REQ-025 In FIX, when signed and the dividend is negative, the remainder is negated; FIX then transitions to DONE.
REQ-026 Latency from the accept edge to out_valid high: 1 cycle on the REQ-020/021 fast paths; XLEN/BPC+2 cycles otherwise (34 cycles for XLEN=32, BPC=1).
REQ-027 DONE holds out_valid, result, out_tag and div_by_zero stable until out_ready=1, then goes to IDLE; there is no accept in the same cycle.
REQ-028 flush=1 forces state to IDLE at the next edge from any state and drops out_valid with no result delivered; flush has priority over accept and out_ready.
REQ-029 A flush asserted in IDLE in the same cycle as in_valid shall discard the request.
REQ-030 result and div_by_zero are registered outputs, not derived combinationally from the inputs.

Reset
REQ-031 Asynchronous assertion of resetn shall force state to IDLE immediately, including mid-CALC; the partial result is discarded.
REQ-032 Reset values: out_valid=0, in_ready=1, result=0, out_tag=0, div_by_zero=0.
REQ-033 Deassertion is synchronised externally; the first accept is permitted on the first edge after deassertion.

Structure
REQ-034 Shared package div_pkg holds the DIV_OP_WIDTH constant, the op encodings (DIV, DIVU, REM, REMU) and the state enum.
REQ-035 Sub-module div_step: a combinational one-bit restoring step parametrised by XLEN, instantiated BPC times in a chain.
REQ-036 The parent module holds the FSM, the iteration counter ($clog2(XLEN/BPC) bits), the operand and sign registers, and the tag register.

Verification
REQ-037 DIV -7 / 2 (XLEN=32, BPC=1) -> out_valid at +34 cycles, result = -3; REM with the same operands -> result = -1.
REQ-038 DIVU 0xFFFFFFFF / 0 -> out_valid at +1 cycle, result 0xFFFFFFFF, div_by_zero=1; REMU with the same operands -> result 0xFFFFFFFF.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> out_valid at +1 cycle, result 0x80000000; REM with the same operands -> result 0.
REQ-040 XLEN=64, BPC=2: DIVU 1000 / 7 -> out_valid at +34 cycles, result 142; REMU with the same operands -> result 6; tag echoed unchanged.
REQ-041 Hold out_ready=0 for 10 cycles in DONE -> result and out_tag stable, in_ready=0; pulse out_ready -> IDLE next cycle, in_ready=1.
REQ-042 Flush, then reset, each at CALC cycle 10 -> IDLE within one cycle (reset immediately), no out_valid; the next request completes with the correct result.
